seq_mag_compare: RTL

- Parametrised, multi-cycle successor to the 74x85-style cascaded magnitude comparator.
- Compares two WIDTH-bit operands SLICE bits per clock, MSB-first, using a start/busy/done handshake.
- Adds signed mode and 74x85-compatible cascade inputs; ends in a registered three-way result.
- Used wherever wide compares must not sit in one combinational path, e.g. sorter and limit-check datapaths.

---
 rtl/seq_mag_compare.sv | 130 +++++++++++++
 1 files changed

// File: rtl/seq_mag_compare.sv
// Multi-cycle MSB-first magnitude comparator with 74x85-style cascade inputs and signed mode.
// Optional macro EARLY_EXIT_EN: finish on the first differing slice instead of always scanning N slices.
module seq_mag_compare #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             altbin,
  input  logic             aeqbin,
  input  logic             agtbin,
  output logic             busy,
  output logic             done,
  output logic             altbout,
  output logic             aeqbout,
  output logic             agtbout
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             signed_q, signed_d;
  logic [2:0]       cas_q, cas_d;
  logic             lt_q, lt_d, gt_q, gt_d;
  logic [2:0]       res_q, res_d;

  logic [SLICE-1:0] slc_a, slc_b;
  logic             new_lt, new_gt, alleq, finish;

  // Current slice; in signed mode flipping the sign bit of the MSB slice turns
  // a two's-complement order into an unsigned one.
  always_comb begin
    slc_a = a_q[cnt_q*SLICE +: SLICE];
    slc_b = b_q[cnt_q*SLICE +: SLICE];
    if (signed_q && (cnt_q == CNT_TOP)) begin
      slc_a[SLICE-1] = ~slc_a[SLICE-1];
      slc_b[SLICE-1] = ~slc_b[SLICE-1];
    end
  end

  // The first differing slice decides; later slices cannot override it.
  assign new_lt = lt_q | (~lt_q & ~gt_q & (slc_a < slc_b));
  assign new_gt = gt_q | (~lt_q & ~gt_q & (slc_a > slc_b));
  assign alleq  = ~(new_lt | new_gt);

`ifdef EARLY_EXIT_EN
  assign finish = (cnt_q == '0) | new_lt | new_gt;
`else
  assign finish = (cnt_q == '0);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    cas_d    = cas_q;
    lt_d     = lt_q;
    gt_d     = gt_q;
    res_d    = res_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d  = RUN;
          cnt_d    = CNT_TOP;
          a_d      = a;
          b_d      = b;
          signed_d = signed_mode;
          cas_d    = {altbin, aeqbin, agtbin};
          lt_d     = 1'b0;
          gt_d     = 1'b0;
        end
      end
      RUN: begin
        lt_d = new_lt;
        gt_d = new_gt;
        if (finish) begin
          state_d = DONE;
          res_d   = {new_lt | (alleq & cas_q[2]),
                     alleq & cas_q[1],
                     new_gt | (alleq & cas_q[0])};
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      cas_q    <= '0;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      cas_q    <= cas_d;
      lt_q     <= lt_d;
      gt_q     <= gt_d;
      res_q    <= res_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign {altbout, aeqbout, agtbout} = res_q;

endmodule
